// File: rtl/xif_result_buffer.sv
// xif_result_buffer: in-order result FIFO between the FPU pipeline and the CORE-V-XIF result channel
//
// Holds finished results in issue order. The head result goes to the core only once its
// offloaded id is committed. A head whose id was killed is popped without producing a result.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   result from the execute pipeline (in_ready = !full)
//   in_id, in_data, in_rd, in_we, in_exc, in_exccode   result fields
//   commit_valid/commit XIF commit handshake {id, commit_kill}
//   result_valid/result_ready/result   XIF result channel (ecswe, ecsdata, dbg, err are always 0)
//
// Optional: define XIF_RESULT_BYPASS_EN so that an already-committed result arriving at an
// idle, empty buffer is loaded straight into the output register (latency 1 instead of 2).

`ifndef QUEUE_DEPTH
`define QUEUE_DEPTH 4
`endif

package in_xif;
    localparam int X_ID_WIDTH = 4;
    localparam int XLEN = 32;
    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;
    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       data;
        logic [4:0]            rd;
        logic                  we;
        logic [2:0]            ecswe;
        logic [5:0]            ecsdata;
        logic                  exc;
        logic [5:0]            exccode;
        logic                  dbg;
        logic                  err;
    } x_result_t;
endpackage

module xif_result_buffer #(
    parameter int DEPTH      = `QUEUE_DEPTH,
    parameter int X_ID_WIDTH = in_xif::X_ID_WIDTH,
    parameter int XLEN       = in_xif::XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [X_ID_WIDTH-1:0] in_id,
    input  logic [XLEN-1:0]       in_data,
    input  logic [4:0]            in_rd,
    input  logic                  in_we,
    input  logic                  in_exc,
    input  logic [5:0]            in_exccode,
    input  logic                  commit_valid,
    input  in_xif::x_commit_t     commit,
    output logic                  result_valid,
    input  logic                  result_ready,
    output in_xif::x_result_t     result
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       data;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, WAIT, PRESENT} state_t;

    state_t                    state, state_next;
    entry_t                    mem [DEPTH];
    entry_t                    head;
    logic [AW:0]               rd_ptr, wr_ptr, count, count_next;
    logic [2**X_ID_WIDTH-1:0]  done, kill;
    logic                      empty, full, push, pop, load, drop, send, byp, byp_q, clr;
    logic [X_ID_WIDTH-1:0]     clr_id;

    assign head         = mem[rd_ptr[AW-1:0]];
    assign count        = wr_ptr - rd_ptr;
    assign empty        = wr_ptr == rd_ptr;
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready     = !full;
    assign result_valid = state == PRESENT;

`ifdef XIF_RESULT_BYPASS_EN
    assign byp = (state == EMPTY) && empty && in_valid && done[in_id] && !kill[in_id];
`else
    assign byp = 1'b0;
`endif

    assign push       = in_valid && in_ready && !byp;
    assign drop       = (state == WAIT) && done[head.id] && kill[head.id];
    assign load       = (state == WAIT) && done[head.id] && !kill[head.id];
    assign send       = result_valid && result_ready;
    // A bypassed result never occupied a FIFO slot, so sending it must not advance rd_ptr.
    assign pop        = drop || (send && !byp_q);
    assign clr        = drop || send;
    assign clr_id     = drop ? head.id : result.id;
    assign count_next = count + PW'(push) - PW'(pop);

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   state_next = byp ? PRESENT : ((push || !empty) ? WAIT : EMPTY);
            WAIT:    state_next = load ? PRESENT : ((drop && count_next == '0) ? EMPTY : WAIT);
            PRESENT: state_next = !send ? PRESENT : ((count_next == '0) ? EMPTY : WAIT);
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{in_id, in_data, in_rd, in_we, in_exc, in_exccode};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            rd_ptr <= '0;
            wr_ptr <= '0;
            done   <= '0;
            kill   <= '0;
            byp_q  <= 1'b0;
            result <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            // The set below is issued after the clear, so a commit reusing the popped id wins.
            if (clr) begin
                done[clr_id] <= 1'b0;
                kill[clr_id] <= 1'b0;
            end
            if (commit_valid) begin
                done[commit.id] <= 1'b1;
                if (commit.commit_kill) kill[commit.id] <= 1'b1;
            end
            if (load) begin
                result <= '{id: head.id, data: head.data, rd: head.rd, we: head.we, ecswe: 3'd0,
                            ecsdata: 6'd0, exc: head.exc, exccode: head.exccode, dbg: 1'b0, err: 1'b0};
                byp_q  <= 1'b0;
            end else if (byp) begin
                result <= '{id: in_id, data: in_data, rd: in_rd, we: in_we, ecswe: 3'd0,
                            ecsdata: 6'd0, exc: in_exc, exccode: in_exccode, dbg: 1'b0, err: 1'b0};
                byp_q  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_xif_result_buffer.sv
// tb_xif_result_buffer: directed and randomized self-checking bench for xif_result_buffer
module tb_xif_result_buffer;
`ifdef XIF_RESULT_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n, in_valid, in_ready, in_we, in_exc, commit_valid, result_valid, result_ready;
    logic [3:0]        in_id;
    logic [31:0]       in_data;
    logic [4:0]        in_rd;
    logic [5:0]        in_exccode;
    in_xif::x_commit_t commit;
    in_xif::x_result_t result;

    int total = 0;
    int bad = 0;

    in_xif::x_result_t exp_q [$];
    logic [3:0]        got_q [$];

    always #5 clk = ~clk;

    xif_result_buffer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_data(in_data), .in_rd(in_rd), .in_we(in_we), .in_exc(in_exc), .in_exccode(in_exccode),
        .commit_valid(commit_valid), .commit(commit), .result_valid(result_valid),
        .result_ready(result_ready), .result(result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic in_xif::x_result_t mk(input logic [3:0] id, input logic [31:0] d,
                                             input logic [4:0] rd, input logic we,
                                             input logic exc, input logic [5:0] ec);
        mk = '0;
        mk.id = id;
        mk.data = d;
        mk.rd = rd;
        mk.we = we;
        mk.exc = exc;
        mk.exccode = ec;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; in_id = '0; in_data = '0; in_rd = '0; in_we = 0; in_exc = 0; in_exccode = '0;
        commit_valid = 0; commit = '0;
    endtask

    task automatic drive(input in_xif::x_result_t e);
        in_valid = 1; in_id = e.id; in_data = e.data; in_rd = e.rd; in_we = e.we;
        in_exc = e.exc; in_exccode = e.exccode;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        cyc();
        cyc();
        rst_n = 1;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic k);
        commit_valid = 1; commit.id = id; commit.commit_kill = k;
        cyc();
        commit_valid = 0;
    endtask

    task automatic do_push(input logic [3:0] id, input logic [31:0] d);
        drive(mk(id, d, 5'(id) + 5'd1, 1'b1, 1'b0, 6'd0));
        cyc();
        in_valid = 0;
    endtask

    task automatic collect(input int n);
        got_q.delete();
        for (int i = 0; i < n; i++) begin
            if (result_valid && result_ready) got_q.push_back(result.id);
            cyc();
        end
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int n;
        n = 0;
        while (!result_valid && n < lim) begin
            cyc();
            n++;
        end
        check(tag, result_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        in_xif::x_result_t held, ent [6];
        logic kl [6];
        int ids [16], cord [6];
        int k, pi, ci, t, j, tmp;
        logic hold;

        result_ready = 0;
        do_reset();
        check("rst_valid", result_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_result", result, 0);
        cyc();
        check("rst_ready2", in_ready, 1);

        do_commit(4'd3, 1'b0);
        drive(mk(4'd3, 32'h12345678, 5'd5, 1'b1, 1'b0, 6'd0));
        cyc();
        in_valid = 0;
        for (int i = 1; i < LAT; i++) begin
            check("lat_early", result_valid, 0);
            cyc();
        end
        check("lat_valid", result_valid, 1);
        check("lat_result", result, mk(4'd3, 32'h12345678, 5'd5, 1'b1, 1'b0, 6'd0));
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("hold_valid", result_valid, 1);
            check("hold_result", result, mk(4'd3, 32'h12345678, 5'd5, 1'b1, 1'b0, 6'd0));
        end
        result_ready = 1;
        cyc();
        result_ready = 0;
        check("sent_valid", result_valid, 0);
        check("sent_ready", in_ready, 1);

        do_push(4'd1, 32'h111);
        do_push(4'd2, 32'h222);
        do_push(4'd3, 32'h333);
        do_commit(4'd2, 1'b1);
        do_commit(4'd1, 1'b0);
        do_commit(4'd3, 1'b0);
        result_ready = 1;
        collect(20);
        result_ready = 0;
        check("kill_n", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("kill_id0", got_q[0], 1);
            check("kill_id1", got_q[1], 3);
        end
        check("kill_empty", result_valid, 0);

        for (int i = 0; i < 4; i++) begin
            check("fill_ready", in_ready, 1);
            do_push(4'(i), 32'hA0 + i);
        end
        check("full_ready", in_ready, 0);
        drive(mk(4'd5, 32'hDEAD, 5'd9, 1'b1, 1'b0, 6'd0));
        cyc();
        cyc();
        in_valid = 0;
        check("full_ready2", in_ready, 0);
        do_commit(4'd0, 1'b0);
        wait_valid("full_valid", 10);
        check("full_res0", result, mk(4'd0, 32'hA0, 5'd1, 1'b1, 1'b0, 6'd0));
        check("full_ready3", in_ready, 0);
        result_ready = 1;
        cyc();
        result_ready = 0;
        check("pop_ready", in_ready, 1);
        do_commit(4'd1, 1'b0);
        do_commit(4'd2, 1'b0);
        do_commit(4'd3, 1'b0);
        do_commit(4'd5, 1'b0);
        result_ready = 1;
        collect(20);
        result_ready = 0;
        check("full_n", got_q.size(), 3);
        for (int i = 0; i < got_q.size() && i < 3; i++) check("full_ids", got_q[i], i + 1);

        do_reset();
        do_commit(4'd4, 1'b0);
        do_push(4'd4, 32'h444);
        do_push(4'd5, 32'h555);
        do_push(4'd6, 32'h666);
        wait_valid("pre_rst_valid", 10);
        check("pre_rst_id", result.id, 4);
        rst_n = 0;
        cyc();
        rst_n = 1;
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_result", result, 0);
        do_commit(4'd5, 1'b0);
        do_commit(4'd6, 1'b0);
        result_ready = 1;
        collect(10);
        result_ready = 0;
        check("mid_rst_none", got_q.size(), 0);
        do_reset();

`ifdef XIF_RESULT_BYPASS_EN
        do_commit(4'd7, 1'b0);
        do_push(4'd7, 32'h777);
        check("byp_valid", result_valid, 1);
        check("byp_id", result.id, 7);
        for (int i = 0; i < 4; i++) do_push(4'(8 + i), 32'h0);
        check("byp_count0", in_ready, 0);
        do_reset();
`endif

        for (int b = 0; b < 60; b++) begin
            for (int i = 0; i < 16; i++) ids[i] = i;
            for (int i = 15; i > 0; i--) begin
                j = $urandom_range(i, 0);
                tmp = ids[i]; ids[i] = ids[j]; ids[j] = tmp;
            end
            k = $urandom_range(6, 1);
            exp_q.delete();
            for (int i = 0; i < k; i++) begin
                ent[i] = mk(4'(ids[i]), $urandom, 5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)),
                            1'($urandom_range(1, 0)), 6'($urandom_range(63, 0)));
                kl[i] = $urandom_range(2, 0) == 0;
                if (!kl[i]) exp_q.push_back(ent[i]);
                cord[i] = i;
            end
            for (int i = k - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                tmp = cord[i]; cord[i] = cord[j]; cord[j] = tmp;
            end
            pi = 0; ci = 0; t = 0; hold = 0;
            while (t < 300 && (pi < k || ci < k || exp_q.size() > 0)) begin
                if (hold) check("rand_hold", result, held);
                result_ready = 1'($urandom_range(1, 0));
                if (result_valid && result_ready) begin
                    if (exp_q.size() == 0) check("rand_extra", result_valid, 0);
                    else check("rand_res", result, exp_q.pop_front());
                end
                hold = result_valid && !result_ready;
                held = result;
                in_valid = 0;
                if (pi < k && in_ready && $urandom_range(1, 0) == 1) begin
                    drive(ent[pi]);
                    pi++;
                end
                commit_valid = 0;
                if (ci < k && $urandom_range(2, 0) == 0) begin
                    commit_valid = 1;
                    commit.id = ent[cord[ci]].id;
                    commit.commit_kill = kl[cord[ci]];
                    ci++;
                end
                cyc();
                t++;
            end
            idle();
            result_ready = 1;
            for (int i = 0; i < 2 * k + 2; i++) begin
                check("rand_extra", result_valid, 0);
                cyc();
            end
            result_ready = 0;
            check("rand_left", exp_q.size(), 0);
            check("rand_drain", in_ready, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xif_result_buffer.md
Name: xif_result_buffer

Overview:
- Writeback-side stage between the FPU execute pipeline and the CORE-V-XIF result channel.
- Queues finished results in order and tracks the commit/kill status of each offloaded id.
- Presents a result to the core only after its id is committed. Results for killed ids are dropped silently.
- Output uses the in_xif::x_result_t packed struct.

Parameters:
- DEPTH, default `QUEUE_DEPTH (4): result FIFO entries; power of two, >=2.
- X_ID_WIDTH, default in_xif::X_ID_WIDTH (4): id width; the commit table has 2**X_ID_WIDTH entries.
- XLEN, default in_xif::XLEN (32): result data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  pipeline result valid.
- in_ready  out  1  buffer can accept; equals !full.
- in_id  in  X_ID_WIDTH  id of the finished instruction.
- in_data  in  XLEN  integer writeback data.
- in_rd  in  5  destination register.
- in_we  in  1  core register write enable.
- in_exc  in  1  synchronous exception flag.
- in_exccode  in  6  exception code.
- commit_valid  in  1  XIF commit handshake valid.
- commit  in  $bits(x_commit_t)  {id, commit_kill}.
- result_valid  out  1  XIF result valid.
- result_ready  in  1  XIF result ready from the core.
- result  out  $bits(x_result_t)  result payload. ecswe=0, ecsdata=0, dbg=0, err=0.

Behaviour:
- Reset (rst_n low at the edge):
  - rd_ptr=wr_ptr=0, count=0, commit table cleared, FSM=EMPTY.
  - result_valid=0, result='0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all entries and commit state; no result completes.
- FIFO:
  - Push on in_valid&&in_ready.
  - Pointers are log2(DEPTH)+1 bits. full = MSBs differ and the rest are equal; empty = pointers equal. Wrap at DEPTH.
  - No push when full: in_ready=0, and in_valid is ignored.
- Commit table, per id bits {done, kill}:
  - commit_valid sets done[id]. If commit_kill is also set, it sets kill[id].
  - Both bits clear when the head entry with that id is popped, either by sending or by dropping.
  - If set and clear hit the same index in the same cycle, set wins (id reuse).
- Head FSM:
  - EMPTY -> WAIT when count>0.
  - WAIT, head done=0: stay.
  - WAIT, done=1, kill=1: drop the head (pop, no result); -> WAIT if count>1, else EMPTY.
  - WAIT, done=1, kill=0: load the output register, result_valid=1; -> PRESENT.
  - PRESENT, result_valid&&result_ready: pop, result_valid=0; -> WAIT or EMPTY. Next-head evaluation starts the following cycle.
  - PRESENT: result is held stable while result_valid && !result_ready.
- Latency, without bypass: push at cycle N with the id already committed -> result_valid at N+2 (N+1 WAIT sees the entry, N+2 registered output).
  - A commit arriving after the push: result_valid 2 cycles after the commit.
- Simultaneous push and pop: allowed when not full; count is unchanged.
- At most one pop per cycle, drop or send.
- Protocol errors: commit for an id with neither an entry nor a later push leaves the table set harmlessly until that id is reused. No error output.

Optional Feature:
- XIF_RESULT_BYPASS_EN defined:
  - When the FSM is EMPTY, the FIFO is empty, in_valid=1, and done[in_id]=1 with kill[in_id]=0 at that cycle, the input is loaded directly into the output register. The FIFO is not written.
  - result_valid asserts the next cycle (latency 1).
- Undefined: all results pass through the FIFO (latency 2).

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> result_valid=0, in_ready=1, result=0.
- Commit id 3 (kill=0), then push id 3, data 0x12345678, rd 5, we 1 at cycle 10 -> result_valid at cycle 12 with id 3, data 0x12345678, rd 5. Held 3 cycles under result_ready=0 with no change.
- Push ids 1,2,3; commit 2 kill=1, 1 and 3 kill=0; result_ready=1 -> results for id 1 then id 3 only; id 2 never appears; count returns to 0.
- Fill DEPTH=4 with ids 0-3, no commits -> in_ready=0, and a 5th in_valid is ignored. Commit 0 -> id 0 sent, in_ready=1 the cycle after the pop.
- Reset asserted while in PRESENT with 2 entries queued -> next cycle result_valid=0, FIFO empty. A later commit of the old ids produces no result.
- With XIF_RESULT_BYPASS_EN: commit id 7, push id 7 at cycle N into an empty buffer -> result_valid at N+1; FIFO count stays 0.
